// File: rtl/alu_result_unloader.sv
// alu_result_unloader: captures the adder result and carry, then streams them out LSB-first byte by byte
module alu_result_unloader #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter bit SEND_FLAGS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] result,
  input  logic              carry,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int NB = DATA_W / BYTE_W;
  localparam int N  = NB + int'(SEND_FLAGS);
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [1:0] {IDLE, SEND, FLAG} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n, shifted;
  logic [IW-1:0] idx, idx_n;
  logic [BYTE_W-1:0] out_data_n;
  logic flag, flag_n, out_valid_n, out_last_n, busy_n, done_n, xfer;
  assign xfer = out_valid && out_ready;
  assign shifted = shreg >> BYTE_W;
  // next-state and next-output selection; every output is registered below
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    flag_n = flag;
    idx_n = idx;
    out_data_n = out_data;
    out_valid_n = out_valid;
    out_last_n = out_last;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: if (load) begin
        shreg_n = result;
        flag_n = carry;
        idx_n = '0;
        out_data_n = result[BYTE_W-1:0];
        out_valid_n = 1'b1;
        out_last_n = (N == 1);
        busy_n = 1'b1;
        state_n = SEND;
      end
      SEND: if (xfer) begin
        if (idx != IW'(NB - 1)) begin
          shreg_n = shifted;
          idx_n = idx + 1'b1;
          out_data_n = shifted[BYTE_W-1:0];
          out_last_n = (idx_n == IW'(NB - 1)) && !SEND_FLAGS;
        end else if (SEND_FLAGS) begin
          out_data_n = BYTE_W'(flag);
          out_last_n = 1'b1;
          state_n = FLAG;
        end else begin
          out_valid_n = 1'b0;
          out_last_n = 1'b0;
          busy_n = 1'b0;
          done_n = 1'b1;
          state_n = IDLE;
        end
      end
      FLAG: if (xfer) begin
        out_valid_n = 1'b0;
        out_last_n = 1'b0;
        busy_n = 1'b0;
        done_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers with synchronous reset abandoning any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      flag <= 1'b0;
      idx <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      flag <= flag_n;
      idx <= idx_n;
      out_data <= out_data_n;
      out_valid <= out_valid_n;
      out_last <= out_last_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_alu_result_unloader.sv
// tb_alu_result_unloader: checks flag and no-flag variants against a queue-based frame model
module tb_alu_result_unloader;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, carry = 1'b0, out_ready = 1'b0;
  logic [31:0] result = '0;
  logic [7:0] od1, od0;
  logic ov1, ol1, b1, dn1, ov0, ol0, b0, dn0;
  logic [7:0] q1[$], q0[$];
  logic [7:0] ed1 = '0, ed0 = '0;
  logic edn1 = 1'b0, edn0 = 1'b0;
  int n_assert = 0, n_fail = 0;
  alu_result_unloader #(.SEND_FLAGS(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .result(result), .carry(carry),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_last(ol1), .busy(b1), .done(dn1)
  );
  alu_result_unloader #(.SEND_FLAGS(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .result(result), .carry(carry),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_last(ol0), .busy(b0), .done(dn0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    if (rst) begin
      q1.delete(); q0.delete();
      ed1 = '0; ed0 = '0; edn1 = 1'b0; edn0 = 1'b0;
    end else begin
      edn1 = 1'b0;
      if (q1.size() == 0) begin
        if (load) begin
          for (int i = 0; i < 4; i++) q1.push_back(result[8*i +: 8]);
          q1.push_back({7'd0, carry});
        end
      end else if (out_ready) begin
        void'(q1.pop_front());
        edn1 = (q1.size() == 0);
      end
      if (q1.size() > 0) ed1 = q1[0];
      edn0 = 1'b0;
      if (q0.size() == 0) begin
        if (load) for (int i = 0; i < 4; i++) q0.push_back(result[8*i +: 8]);
      end else if (out_ready) begin
        void'(q0.pop_front());
        edn0 = (q0.size() == 0);
      end
      if (q0.size() > 0) ed0 = q0[0];
    end
    @(posedge clk);
    #1;
    chk("f1.data", 32'(od1), 32'(ed1));
    chk("f1.ctl {valid,last,busy,done}", 32'({ov1, ol1, b1, dn1}),
        32'({q1.size() > 0, q1.size() == 1, q1.size() > 0, edn1}));
    chk("f0.data", 32'(od0), 32'(ed0));
    chk("f0.ctl {valid,last,busy,done}", 32'({ov0, ol0, b0, dn0}),
        32'({q0.size() > 0, q0.size() == 1, q0.size() > 0, edn0}));
  endtask
  task automatic drive(input logic r, input logic l, input logic [31:0] res, input logic c, input logic rdy, input int n);
    rst = r; load = l; result = res; carry = c; out_ready = rdy;
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    drive(1, 1, 32'h12345678, 1, 1, 3);
    drive(0, 1, 32'h12345678, 1, 1, 1);
    drive(0, 0, 32'h0, 0, 1, 7);
    drive(0, 1, 32'h12345678, 1, 0, 1);
    for (int i = 0; i < 14; i++) drive(0, 0, 32'h0, 0, (i % 3) != 1, 1);
    drive(0, 0, 32'h0, 0, 1, 3);
    drive(0, 1, 32'hFFFFFFFF, 0, 1, 1);
    drive(0, 1, 32'h0, 1, 1, 4);
    drive(0, 0, 32'h0, 0, 1, 8);
    drive(0, 1, 32'h12345678, 1, 1, 1);
    drive(0, 0, 32'h0, 0, 1, 2);
    drive(1, 0, 32'h0, 0, 1, 1);
    drive(0, 0, 32'h0, 0, 1, 1);
    drive(0, 1, 32'h000000A5, 0, 1, 1);
    drive(0, 0, 32'h0, 0, 1, 7);
    drive(0, 1, 32'hDEADBEEF, 0, 1, 1);
    drive(0, 0, 32'h0, 0, 1, 4);
    drive(0, 1, 32'hCAFEF00D, 1, 1, 1);
    drive(0, 0, 32'h0, 0, 1, 8);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
